// File: rtl/pipe_result_accum.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_result_accum
//  Purpose  : Frame accumulator for the multi_pipeline result stream. It sums
//             every N accepted samples into one saturating frame total and
//             holds that total in a single-entry output register until the
//             consumer takes it.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DW        input sample width (matches multi_pipeline.out)
//    N         samples per frame, 2..256
//    SW        output sum width, SW >= DW; the sum saturates at 2^SW-1
//  Ports
//    clk       single clock, all state on the rising edge
//    rst_n     asynchronous assert, active-low reset
//    in_valid  in_data carries a sample this cycle
//    in_data   unsigned sample
//    in_ready  block accepts the presented sample this cycle
//    clr       synchronous discard of the partial frame (output untouched)
//    out_valid out_data/out_sat hold a completed frame
//    out_ready consumer takes the result this cycle
//    out_data  saturated frame sum
//    out_sat   saturation occurred somewhere in this frame
// ============================================================================
module pipe_result_accum #(
    parameter int DW = 12,
    parameter int N  = 4,
    parameter int SW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic          clr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] out_data,
    output logic          out_sat
);

    // Counter wide enough for 0..N-1.
    localparam int            C_CW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [C_CW-1:0] C_LAST  = C_CW'(N - 1);
    localparam logic [SW-1:0] C_SUM_MAX = {SW{1'b1}};

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t            state_q,    state_d;
    logic [SW-1:0]     acc_q,      acc_d;
    logic [C_CW-1:0]   cnt_q,      cnt_d;
    logic              sat_acc_q,  sat_acc_d;
    logic [SW-1:0]     out_data_q, out_data_d;
    logic              out_sat_q,  out_sat_d;

    // ------------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------------
    logic              w_last;
    logic              w_accept;
    logic              w_complete;
    logic              w_transfer;
    logic [SW:0]       w_sum;
    logic              w_ovf;
    logic [SW-1:0]     w_sum_sat;

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    assign w_last    = (cnt_q == C_LAST);

    // Only the closing sample of a frame can be blocked, and only while the
    // previous result is still unconsumed. Partial-frame samples never wait.
    assign in_ready  = !(out_valid && !out_ready && w_last);

    // A sample presented alongside clr is dropped rather than accumulated.
    assign w_accept   = in_valid && in_ready && !clr;
    assign w_complete = w_accept && w_last;
    assign w_transfer = out_valid && out_ready;

    // One extra bit catches the carry out of the SW-bit sum. Once acc sits at
    // the ceiling any non-zero sample overflows again, so a saturated frame
    // stays pinned at the maximum.
    assign w_sum     = {1'b0, acc_q} + {{(SW + 1 - DW){1'b0}}, in_data};
    assign w_ovf     = w_sum[SW];
    assign w_sum_sat = w_ovf ? C_SUM_MAX : w_sum[SW-1:0];

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sat_acc_d  = sat_acc_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        state_d    = state_q;

        // Accumulator side
        if (clr) begin
            acc_d     = '0;
            cnt_d     = '0;
            sat_acc_d = 1'b0;
        end else if (w_accept) begin
            if (w_last) begin
                out_data_d = w_sum_sat;
                out_sat_d  = sat_acc_q | w_ovf;
                acc_d      = '0;
                cnt_d      = '0;
                sat_acc_d  = 1'b0;
            end else begin
                acc_d     = w_sum_sat;
                sat_acc_d = sat_acc_q | w_ovf;
                cnt_d     = cnt_q + C_CW'(1);
            end
        end

        // Output holding register. A completion that coincides with a
        // transfer replaces the old result, which counts as taken.
        case (state_q)
            ST_EMPTY: begin
                if (w_complete) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_complete) begin
                    state_d = ST_FULL;
                end else if (w_transfer) begin
                    state_d = ST_EMPTY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            acc_q      <= '0;
            cnt_q      <= '0;
            sat_acc_q  <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sat_acc_q  <= sat_acc_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_result_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_result_accum
//  Purpose  : Directed and randomised checks of pipe_result_accum. Two
//             instances share all inputs: the default SW=16 build and an
//             SW=13 build that saturates on full-scale frames.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_result_accum;

    localparam int DW = 12;
    localparam int N  = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          clr;
    logic          out_ready;

    logic          in_ready;
    logic          out_valid;
    logic [15:0]   out_data;
    logic          out_sat;

    logic          in_ready13;
    logic          out_valid13;
    logic [12:0]   out_data13;
    logic          out_sat13;

    int errors = 0;
    int checks = 0;

    pipe_result_accum #(.DW(DW), .N(N), .SW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    pipe_result_accum #(.DW(DW), .N(N), .SW(13)) dut13 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready13),
        .clr       (clr),
        .out_valid (out_valid13),
        .out_ready (out_ready),
        .out_data  (out_data13),
        .out_sat   (out_sat13)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; the DUT samples them on the rising one.
    task automatic send(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        clr = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 16'd0) begin errors++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
        checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL reset_out_sat got=%b exp=0", out_sat); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_basic();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready i=%0d got=%b exp=1", i, in_ready); end
            if (i == 4) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
            end
            @(negedge clk);
        end
        idle();
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 16'd10) begin errors++; $display("FAIL basic_data got=%0d exp=10", out_data); end
        checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL basic_sat got=%b exp=0", out_sat); end
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got=%b exp=0", out_valid); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_stall();
        out_ready = 1'b1;
        send(12'd5); send(12'd5); send(12'd3); send(12'd3);
        idle();
        out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 16'd16) begin errors++; $display("FAIL stall_first got=%b/%0d exp=1/16", out_valid, out_data); end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 12'd7;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_partial_ready i=%0d got=%b exp=1", i, in_ready); end
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = 12'd7;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_last_blocked got=%b exp=0", in_ready); end
        @(negedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_still_blocked got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_data !== 16'd16) begin errors++; $display("FAIL stall_hold got=%b/%0d exp=1/16", out_valid, out_data); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 16'd28) begin errors++; $display("FAIL stall_second got=%b/%0d exp=1/28", out_valid, out_data); end
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got=%b exp=0", out_valid); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_saturation();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(12'd4095);
        idle();
        #1;
        checks++; if (out_valid13 !== 1'b1 || out_data13 !== 13'd8191) begin errors++; $display("FAIL sat13_data got=%b/%0d exp=1/8191", out_valid13, out_data13); end
        checks++; if (out_sat13 !== 1'b1) begin errors++; $display("FAIL sat13_flag got=%b exp=1", out_sat13); end
        checks++; if (out_data !== 16'd16380 || out_sat !== 1'b0) begin errors++; $display("FAIL sat16_nosat got=%0d/%b exp=16380/0", out_data, out_sat); end
        for (int i = 0; i < 4; i++) send(12'd1);
        idle();
        #1;
        checks++; if (out_valid13 !== 1'b1 || out_data13 !== 13'd4) begin errors++; $display("FAIL sat13_next got=%b/%0d exp=1/4", out_valid13, out_data13); end
        checks++; if (out_sat13 !== 1'b0) begin errors++; $display("FAIL sat13_flag_cleared got=%b exp=0", out_sat13); end
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_clr();
        out_ready = 1'b1;
        send(12'd9); send(12'd9);
        clr = 1'b1;
        send(12'd9);
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(12'd2);
            #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_early_valid i=%0d got=%b exp=0", i, out_valid); end
        end
        send(12'd2);
        idle();
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 16'd8) begin errors++; $display("FAIL clr_result got=%b/%0d exp=1/8", out_valid, out_data); end
        // clr must leave a pending result untouched.
        out_ready = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 16'd8) begin errors++; $display("FAIL clr_keeps_output got=%b/%0d exp=1/8", out_valid, out_data); end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(12'd3);
        send(12'd4); send(12'd4);
        idle();
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 16'd12) begin errors++; $display("FAIL arst_pre got=%b/%0d exp=1/12", out_valid, out_data); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 16'd0 || out_sat !== 1'b0) begin errors++; $display("FAIL arst_outputs got=%b/%0d/%b exp=0/0/0", out_valid, out_data, out_sat); end
        checks++; if (out_valid13 !== 1'b0 || out_data13 !== 13'd0) begin errors++; $display("FAIL arst_outputs13 got=%b/%0d exp=0/0", out_valid13, out_data13); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(12'd1);
            #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_early_valid i=%0d got=%b exp=0", i, out_valid); end
        end
        send(12'd1);
        idle();
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 16'd4) begin errors++; $display("FAIL arst_result got=%b/%0d exp=1/4", out_valid, out_data); end
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_random();
        int m_cnt, m_acc16, m_acc13, m_d16, m_d13;
        bit m_sat16, m_sat13, m_ov, m_s16, m_s13;
        int sum16, sum13, frames_exp, frames_got;
        bit exp_rdy, acc_ok, ovf16, ovf13, done;

        rst_n = 1'b0;
        idle();
        clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_cnt = 0; m_acc16 = 0; m_acc13 = 0; m_d16 = 0; m_d13 = 0;
        m_sat16 = 0; m_sat13 = 0; m_ov = 0; m_s16 = 0; m_s13 = 0;
        frames_exp = 0; frames_got = 0;

        for (int cyc = 0; cyc < 1000; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = DW'($urandom_range(0, 4095));
            clr       = ($urandom_range(0, 31) == 0);
            out_ready = ($urandom_range(0, 1) == 1);
            #1;
            exp_rdy = !(m_ov && !out_ready && m_cnt == N - 1);
            checks++; if (in_ready !== exp_rdy || in_ready13 !== exp_rdy) begin errors++; $display("FAIL rnd_in_ready cyc=%0d got=%b/%b exp=%b", cyc, in_ready, in_ready13, exp_rdy); end
            checks++; if (out_valid !== m_ov || out_valid13 !== m_ov) begin errors++; $display("FAIL rnd_out_valid cyc=%0d got=%b/%b exp=%b", cyc, out_valid, out_valid13, m_ov); end
            if (m_ov) begin
                checks++; if (out_data !== 16'(m_d16) || out_sat !== m_s16) begin errors++; $display("FAIL rnd_data16 cyc=%0d got=%0d/%b exp=%0d/%b", cyc, out_data, out_sat, m_d16, m_s16); end
                checks++; if (out_data13 !== 13'(m_d13) || out_sat13 !== m_s13) begin errors++; $display("FAIL rnd_data13 cyc=%0d got=%0d/%b exp=%0d/%b", cyc, out_data13, out_sat13, m_d13, m_s13); end
                if (out_ready) frames_got++;
            end

            acc_ok = in_valid && exp_rdy && !clr;
            done   = 1'b0;
            if (clr) begin
                m_cnt = 0; m_acc16 = 0; m_acc13 = 0; m_sat16 = 0; m_sat13 = 0;
            end else if (acc_ok) begin
                sum16 = m_acc16 + int'(in_data);
                sum13 = m_acc13 + int'(in_data);
                ovf16 = (sum16 > 65535);
                ovf13 = (sum13 > 8191);
                if (ovf16) sum16 = 65535;
                if (ovf13) sum13 = 8191;
                if (m_cnt == N - 1) begin
                    m_d16 = sum16; m_s16 = m_sat16 | ovf16;
                    m_d13 = sum13; m_s13 = m_sat13 | ovf13;
                    m_cnt = 0; m_acc16 = 0; m_acc13 = 0; m_sat16 = 0; m_sat13 = 0;
                    done = 1'b1;
                    frames_exp++;
                end else begin
                    m_acc16 = sum16; m_sat16 = m_sat16 | ovf16;
                    m_acc13 = sum13; m_sat13 = m_sat13 | ovf13;
                    m_cnt++;
                end
            end
            if (done) m_ov = 1'b1;
            else if (m_ov && out_ready) m_ov = 1'b0;
            @(negedge clk);
        end
        idle();
        clr = 1'b0;
        out_ready = 1'b1;
        #1;
        if (m_ov && out_valid) frames_got++;
        checks++; if (frames_got !== frames_exp) begin errors++; $display("FAIL rnd_frame_count got=%0d exp=%0d", frames_got, frames_exp); end
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        clr = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_saturation();
        test_clr();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_result_accum.md
# pipe_result_accum

Frame accumulator directly downstream of `multi_pipeline`. It consumes the 12-bit `out` result stream through a valid/ready handshake and sums every N accepted samples into one saturating frame total. It holds that total in a single-entry output register until the consumer accepts it. A frame only stalls when its last sample would overwrite an unconsumed result.

## Interface
- `DW`, 12: input sample width; matches `multi_pipeline.out`.
- `N`, 4: samples per frame; legal range 2..256.
- `SW`, 16: output sum width; SW ≥ DW required; saturates at 2^SW−1.
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low; synchronous release assumed from the reset tree.
- `in_valid` in 1: `in_data` is valid this cycle.
- `in_data` in DW: unsigned sample from `multi_pipeline.out`.
- `in_ready` out 1: block accepts the sample this cycle.
- `clr` in 1: synchronous discard of the partial frame; does not touch the output register.
- `out_valid` out 1: `out_data` and `out_sat` hold a completed frame.
- `out_ready` in 1: consumer takes the result this cycle.
- `out_data` out SW: frame sum, unsigned, saturated.
- `out_sat` out 1: saturation occurred in this frame.

## Operation
- Accept means `in_valid && in_ready`. A transfer means `out_valid && out_ready`.
- Internal state:
  - `acc` (SW bits)
  - `cnt` (0..N−1)
  - `sat_acc` (sticky flag)
  - output register {`out_data`, `out_sat`}
  - `out_valid`
- Saturating add: `nxt = acc + in_data`, computed at SW+1 bits. If `nxt` ≥ 2^SW, the result is 2^SW−1 and the saturation flag is set. Once `acc` saturates, it stays saturated for the rest of the frame.
- Accept with `cnt < N−1`:
  - `acc ← sat(nxt)`
  - `sat_acc ← sat_acc | ovf`
  - `cnt++`
- Accept with `cnt == N−1` (frame completes):
  - `out_data ← sat(nxt)`
  - `out_sat ← sat_acc | ovf`
  - `out_valid ← 1`
  - `acc ← 0`, `sat_acc ← 0`, `cnt ← 0`
- Output FSM, two states:
  - EMPTY (`out_valid` = 0): goes to FULL on frame completion.
  - FULL (`out_valid` = 1): goes to EMPTY on transfer without completion. Stays FULL if a completion coincides with a transfer; the new result replaces the old one, and the old one counts as taken.
- `in_ready = !(out_valid && !out_ready && cnt == N−1)`. This is combinational from `out_ready` and registered state; there is no path from `in_valid`. Partial-frame samples are always accepted.
- `clr`:
  - Forces `acc`, `cnt` and `sat_acc` to 0, and `in_ready` is ignored that cycle.
  - A sample presented in the same cycle is dropped, not accumulated.
  - The output register and `out_valid` are unaffected; a transfer in the same cycle still completes.
- `out_data` and `out_sat` stay stable while `out_valid && !out_ready`.

## Timing
- Reset values (async on `rst_n` = 0):
  - `acc` = 0, `cnt` = 0, `sat_acc` = 0
  - `out_valid` = 0, `out_data` = 0, `out_sat` = 0
  - `in_ready` = 1 (follows from `out_valid` = 0)
- Reset mid-frame discards the partial sum and any pending result. The first accept after `rst_n` rises counts as sample 0.
- Latency: `out_valid` rises on the edge that accepts sample N−1, so the result is visible one cycle after that sample is presented.
- Throughput: one sample per cycle sustained when `out_ready` = 1.
- Back-to-back frames: when `out_ready` is held at 1, `out_valid` pulses for exactly one cycle every N cycles.
- Stall: only the last sample of a frame waits. It is accepted in the same cycle that `out_ready` takes the pending result.

## Test plan
- Reset, then `out_ready` = 1; stream 1, 2, 3, 4 on consecutive cycles -> `out_data` = 10, `out_sat` = 0, `out_valid` high one cycle after sample 4, then low.
- Hold `out_ready` = 0 after frame {5, 5, 3, 3} (sum 16); send 7, 7, 7, 7 -> first three accepted, `in_ready` = 0 on the fourth. Raise `out_ready` -> 16 transfers and the fourth 7 is accepted the same cycle; next result is 28.
- Override SW = 13; send 4095 ×4 -> `out_data` = 8191, `out_sat` = 1. Next frame 1, 1, 1, 1 -> 4, `out_sat` = 0.
- Send 9, 9, then assert `clr` together with `in_valid` and 9; then send 2, 2, 2, 2 -> result 8. The cleared sample is not counted.
- Send 4, 4 (partial frame), assert `rst_n` = 0 asynchronously between edges -> `out_valid`, `out_data` and `out_sat` are 0 immediately. After release, 1, 1, 1, 1 -> 4.
- Continuous 1000-cycle random stream with random `out_ready`, checked against a scoreboard model -> every frame sum and saturation flag matches, with no loss or duplication.
